// File: rtl/core101_pkg.sv
// Shared Core101 decode constants: base opcodes and immediate format codes.
package core101_pkg;

  // Base opcodes, ins[6:0]
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Immediate format codes carried with every result
  localparam logic [2:0] IMM_FMT_NONE  = 3'd0;
  localparam logic [2:0] IMM_FMT_I     = 3'd1;
  localparam logic [2:0] IMM_FMT_S     = 3'd2;
  localparam logic [2:0] IMM_FMT_B     = 3'd3;
  localparam logic [2:0] IMM_FMT_U     = 3'd4;
  localparam logic [2:0] IMM_FMT_J     = 3'd5;
  localparam logic [2:0] IMM_FMT_SHAMT = 3'd6;
  localparam logic [2:0] IMM_FMT_Z     = 3'd7;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate classifier/extender.
// Optional macro IMM_GEN_ZICSR_EN: SYSTEM opcodes with funct3[2]=1 produce
// format Z (uimm in ins[19:15]); without it every SYSTEM encoding is format I.
module imm_extract
  import core101_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ins,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] value
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               is_shift;
  logic [5:0]         shamt;
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;

  assign opcode   = ins[6:0];
  assign funct3   = ins[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Raw fields in standard RISC-V bit placement; the signed type makes the
  // later width cast sign-extend from ins[31].
  assign imm_i = ins[31:20];
  assign imm_s = {ins[31:25], ins[11:7]};
  assign imm_b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  // RV64 OP-IMM shifts use a 6-bit shamt; RV32 and the *W shifts use 5 bits.
  assign shamt = ((XLEN == 64) && (opcode == OP_IMM)) ? ins[25:20] : {1'b0, ins[24:20]};

  // Classify the immediate format from the opcode (and funct3 where needed)
  always_comb begin
    fmt = IMM_FMT_NONE;
    case (opcode)
      OP_LUI, OP_AUIPC: fmt = IMM_FMT_U;
      OP_JAL:           fmt = IMM_FMT_J;
      OP_JALR:          fmt = IMM_FMT_I;
      OP_BRANCH:        fmt = IMM_FMT_B;
      OP_LOAD:          fmt = IMM_FMT_I;
      OP_STORE:         fmt = IMM_FMT_S;
      OP_IMM:           fmt = is_shift ? IMM_FMT_SHAMT : IMM_FMT_I;
      OP_IMM32: begin
        // The *W opcodes only exist on RV64
        if (XLEN == 64) fmt = is_shift ? IMM_FMT_SHAMT : IMM_FMT_I;
      end
      OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
        fmt = funct3[2] ? IMM_FMT_Z : IMM_FMT_I;
`else
        fmt = IMM_FMT_I;
`endif
      end
      default: fmt = IMM_FMT_NONE;
    endcase
  end

  // Extend the selected field to XLEN; unknown formats yield zero
  always_comb begin
    value = '0;
    case (fmt)
      IMM_FMT_I:     value = XLEN'(imm_i);
      IMM_FMT_S:     value = XLEN'(imm_s);
      IMM_FMT_B:     value = XLEN'(imm_b);
      IMM_FMT_U:     value = XLEN'(imm_u);
      IMM_FMT_J:     value = XLEN'(imm_j);
      IMM_FMT_SHAMT: value = XLEN'(shamt);
      IMM_FMT_Z:     value = XLEN'(ins[19:15]);
      default:       value = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: classify/extend each accepted
// instruction and buffer the result in a DEPTH-entry FIFO.
// Optional macro IMM_GEN_ZICSR_EN (handled inside imm_extract) enables format Z.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. ins_ready_output depends only on registered occupancy; the producer may
// not make ins_valid_input depend on it combinationally in a way that loops.
// imm_valid_output is high whenever an entry is buffered, and the head entry
// (value/fmt/tag) is held stable until imm_ready_input is seen high with it.
module imm_gen_stage
  import core101_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                     clk_input,
  input  logic                     rst_input,
  input  logic                     flush_input,
  input  logic [31:0]              ins_input,
  input  logic [TAG_W-1:0]         ins_tag_input,
  input  logic                     ins_valid_input,
  output logic                     ins_ready_output,
  output logic [XLEN-1:0]          imm_value_output,
  output logic [2:0]               imm_fmt_output,
  output logic [TAG_W-1:0]         imm_tag_output,
  output logic                     imm_valid_output,
  input  logic                     imm_ready_input,
  output logic [$clog2(DEPTH):0]   occupancy_output
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [2:0]       fmt;
    logic [XLEN-1:0]  value;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             push;
  logic             pop;
  logic [2:0]       ext_fmt;
  logic [XLEN-1:0]  ext_value;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .ins   (ins_input),
    .fmt   (ext_fmt),
    .value (ext_value)
  );

  assign new_entry = '{tag: ins_tag_input, fmt: ext_fmt, value: ext_value};

  // Ready and valid come from registered occupancy only, so a pop in the same
  // cycle never frees a slot for a push while full.
  assign ins_ready_output = (occ < DEPTH_OCC);
  assign imm_valid_output = (occ != '0);
  assign push             = ins_valid_input && ins_ready_output && !flush_input;
  assign pop              = imm_valid_output && imm_ready_input && !flush_input;

  // Pointers and occupancy; flush and reset empty the FIFO and win over push/pop.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_input) begin
    if (rst_input || flush_input) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage write; contents need no reset because the head is masked when empty
  always_ff @(posedge clk_input) begin
    if (push && !rst_input) mem[wr_ptr] <= new_entry;
  end

  // Head outputs are forced to zero whenever nothing is buffered
  always_comb begin
    head = '0;
    if (imm_valid_output) head = mem[rd_ptr];
  end

  assign imm_value_output = head.value;
  assign imm_fmt_output   = head.fmt;
  assign imm_tag_output   = head.tag;
  assign occupancy_output = occ;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed + lightly randomised bench for imm_gen_stage (XLEN=32, DEPTH=2)
// with a second XLEN=64 instance for the RV64-only encodings.
module tb_imm_gen_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int TAG_W = 5;
  localparam int W     = TAG_W + 3 + XLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             flush;
  logic [31:0]      ins;
  logic [TAG_W-1:0] ins_tag;
  logic             ins_valid;
  logic             ins_ready;
  logic [XLEN-1:0]  imm_value;
  logic [2:0]       imm_fmt;
  logic [TAG_W-1:0] imm_tag;
  logic             imm_valid;
  logic             imm_ready;
  logic [1:0]       occupancy;

  logic [31:0]      w_ins;
  logic [TAG_W-1:0] w_tag;
  logic             w_valid;
  logic             w_ready;
  logic [63:0]      w_value;
  logic [2:0]       w_fmt;
  logic [TAG_W-1:0] w_out_tag;
  logic             w_out_valid;
  logic [1:0]       w_occ;

  imm_gen_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_input        (clk),
    .rst_input        (rst),
    .flush_input      (flush),
    .ins_input        (ins),
    .ins_tag_input    (ins_tag),
    .ins_valid_input  (ins_valid),
    .ins_ready_output (ins_ready),
    .imm_value_output (imm_value),
    .imm_fmt_output   (imm_fmt),
    .imm_tag_output   (imm_tag),
    .imm_valid_output (imm_valid),
    .imm_ready_input  (imm_ready),
    .occupancy_output (occupancy)
  );

  imm_gen_stage #(.XLEN(64), .DEPTH(2), .TAG_W(TAG_W)) dut64 (
    .clk_input        (clk),
    .rst_input        (rst),
    .flush_input      (1'b0),
    .ins_input        (w_ins),
    .ins_tag_input    (w_tag),
    .ins_valid_input  (w_valid),
    .ins_ready_output (w_ready),
    .imm_value_output (w_value),
    .imm_fmt_output   (w_fmt),
    .imm_tag_output   (w_out_tag),
    .imm_valid_output (w_out_valid),
    .imm_ready_input  (1'b1),
    .occupancy_output (w_occ)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pend;
  logic         accepted;
  int           checks   = 0;
  int           failures = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock: compare the DUT against the scoreboard, then advance the model.
  task automatic tick();
    logic m_push;
    logic m_pop;
    #1;
    check("occupancy", 64'(occupancy), 64'(exp_q.size()));
    check("ins_ready", 64'(ins_ready), 64'(exp_q.size() < DEPTH));
    check("imm_valid", 64'(imm_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("head", 64'({imm_tag, imm_fmt, imm_value}), 64'(exp_q[0]));
    else                   check("head_masked", 64'({imm_tag, imm_fmt, imm_value}), 64'(0));
    m_push = ins_valid && (exp_q.size() < DEPTH) && !flush;
    m_pop  = (exp_q.size() != 0) && imm_ready && !flush;
    @(posedge clk);
    if (rst || flush) exp_q.delete();
    else begin
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(pend);
    end
    accepted = m_push && !rst;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] i, input logic [TAG_W-1:0] t,
                       input logic [XLEN-1:0] v, input logic [2:0] f);
    ins       = i;
    ins_tag   = t;
    ins_valid = 1'b1;
    pend      = {t, f, v};
  endtask

  task automatic send(input logic [31:0] i, input logic [TAG_W-1:0] t,
                      input logic [XLEN-1:0] v, input logic [2:0] f);
    int tries;
    drive(i, t, v, f);
    accepted = 1'b0;
    tries    = 0;
    while (!accepted && tries < 10) begin
      tick();
      tries++;
    end
    if (!accepted) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted ins=%h", i);
    end
  endtask

  task automatic idle(input int n);
    ins_valid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send64(input string name, input logic [31:0] i,
                        input logic [63:0] v, input logic [2:0] f);
    logic [TAG_W-1:0] t;
    t       = TAG_W'($urandom_range(0, 31));
    w_ins   = i;
    w_tag   = t;
    w_valid = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    check({name, "_valid"}, 64'(w_out_valid), 64'(1));
    check({name, "_value"}, w_value, v);
    check({name, "_fmt"},   64'(w_fmt), 64'(f));
    check({name, "_tag"},   64'(w_out_tag), 64'(t));
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] imm12;
    rst       = 1'b1;
    flush     = 1'b0;
    ins       = '0;
    ins_tag   = '0;
    ins_valid = 1'b0;
    imm_ready = 1'b1;
    pend      = '0;
    accepted  = 1'b0;
    w_ins     = '0;
    w_tag     = '0;
    w_valid   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst64_occ",   64'(w_occ), 64'(0));
    check("rst64_ready", 64'(w_ready), 64'(1));
    check("rst64_value", w_value, 64'(0));
    idle(1);

    // Single addi, result visible one cycle later
    send(32'hFFF00093, 5'd3, 32'hFFFFFFFF, 3'd1);
    idle(2);

    // Back-to-back S, B, U with consumer always ready
    send(32'h00112623, 5'd4, 32'h0000000C, 3'd2);
    send(32'hFE000EE3, 5'd5, 32'hFFFFFFFC, 3'd3);
    send(32'h123452B7, 5'd6, 32'h12345000, 3'd4);
    idle(3);

    // Other formats and the NONE cases
    send(32'h008000EF, 5'd7,  32'h00000008, 3'd5);  // jal x1, 8
    send(32'h000080E7, 5'd8,  32'h00000000, 3'd1);  // jalr x1, 0(x1)
    send(32'hFFC0A083, 5'd9,  32'hFFFFFFFC, 3'd1);  // lw x1, -4(x1)
    send(32'h01F09093, 5'd10, 32'h0000001F, 3'd6);  // slli x1, x1, 31
    send(32'h43F0D093, 5'd11, 32'h0000001F, 3'd6);  // srai: 5-bit shamt on RV32
    send(32'h00000033, 5'd12, 32'h00000000, 3'd0);  // add: no immediate
    send(32'h0010909B, 5'd13, 32'h00000000, 3'd0);  // slliw is not RV32
    send(32'h34009073, 5'd14, 32'h00000340, 3'd1);  // csrrw
`ifdef IMM_GEN_ZICSR_EN
    send(32'h3400D073, 5'd15, 32'h00000001, 3'd7);  // csrrwi x0, 0x340, 1
`else
    send(32'h3400D073, 5'd15, 32'h00000340, 3'd1);
`endif
    idle(3);

    // Back-pressure: fill, stall the third, then drain in order
    imm_ready = 1'b0;
    send(32'h00100093, 5'd16, 32'h00000001, 3'd1);
    send(32'h00200093, 5'd17, 32'h00000002, 3'd1);
    drive(32'h00300093, 5'd18, 32'h00000003, 3'd1);
    tick();
    tick();
    imm_ready = 1'b1;
    tick();  // pop while full: third still refused this cycle
    check("full_pop_no_push", 64'(accepted), 64'(0));
    send(32'h00300093, 5'd18, 32'h00000003, 3'd1);
    idle(4);

    // Flush while full with a simultaneous push
    imm_ready = 1'b0;
    send(32'h00400093, 5'd19, 32'h00000004, 3'd1);
    send(32'h00500093, 5'd20, 32'h00000005, 3'd1);
    drive(32'h00600093, 5'd21, 32'h00000006, 3'd1);
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    ins_valid = 1'b0;
    imm_ready = 1'b1;
    idle(3);

    // Reset mid-operation
    imm_ready = 1'b0;
    send(32'h00700093, 5'd22, 32'h00000007, 3'd1);
    ins_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imm_ready = 1'b1;
    idle(2);

    // Random addi stream with random valid/ready
    ins_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!ins_valid || accepted) begin
        imm12 = 12'($urandom_range(0, 4095));
        drive({imm12, 5'($urandom_range(0, 31)), 3'b000, 5'($urandom_range(0, 31)), 7'b0010011},
              5'($urandom_range(0, 31)), {{20{imm12[11]}}, imm12}, 3'd1);
        ins_valid = 1'($urandom_range(0, 1));
      end
      imm_ready = 1'($urandom_range(0, 1));
      tick();
    end
    imm_ready = 1'b1;
    idle(4);

    // RV64 instance
    send64("rv64_addi",  32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    send64("rv64_srai",  32'h43F0D093, 64'h000000000000003F, 3'd6);
    send64("rv64_slliw", 32'h01F0909B, 64'h000000000000001F, 3'd6);
    send64("rv64_addiw", 32'hFFF0809B, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    send64("rv64_lui",   32'h800000B7, 64'hFFFFFFFF80000000, 3'd4);
    check("rv64_empty_value", w_value, 64'(0));
    check("rv64_empty_occ", 64'(w_occ), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-generation stage for Core101.
- Sits between fetch/decode and register read.
- Accepts raw 32-bit instructions with a tag over a valid/ready handshake, classifies the immediate format, and sign- or zero-extends the immediate to XLEN.
- Results are buffered in a small FIFO so downstream stalls do not immediately back-pressure fetch.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- DEPTH, 2, output FIFO entries; power of two, at least 2.
- TAG_W, 5, width of the opaque tag (ROB index or PC slot) carried with each instruction.

Ports:
- clk_input  in  1  core clock; all logic on the rising edge.
- rst_input  in  1  synchronous, active-high reset.
- flush_input  in  1  drops all buffered entries.
- ins_input  in  32  raw instruction word.
- ins_tag_input  in  TAG_W  tag accompanying ins_input.
- ins_valid_input  in  1  ins_input is valid.
- ins_ready_output  out  1  stage can accept an instruction.
- imm_value_output  out  XLEN  extended immediate at the FIFO head.
- imm_fmt_output  out  3  format code at the head.
- imm_tag_output  out  TAG_W  tag at the head.
- imm_valid_output  out  1  head entry is valid.
- imm_ready_input  in  1  consumer accepts the head entry.
- occupancy_output  out  log2(DEPTH)+1  number of buffered entries.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - occupancy 0, imm_valid 0, ins_ready 1.
  - Read/write pointers 0.
  - imm_value, imm_fmt and imm_tag drive 0 whenever the FIFO is empty (masked), including out of reset.
- Format codes: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 Z.
- Classification on opcode ins[6:0]:
  - 0110111 and 0010111 → U.
  - 1101111 → J.
  - 1100111 → I.
  - 1100011 → B.
  - 0000011 → I.
  - 0100011 → S.
  - 0010011 → I, or SHAMT when funct3 is 001 or 101.
  - 0011011 → SHAMT (funct3 001/101) or I, only when XLEN=64; otherwise NONE.
  - 1110011 → I (see Optional Feature for the Z case).
  - Anything else → NONE with immediate 0.
- Extension rules:
  - I, S, B, U and J use standard RISC-V bit placement, sign-extended from ins[31] to XLEN.
  - U is ins[31:12] followed by twelve zeros.
  - SHAMT is zero-extended: ins[24:20] for XLEN=32 or for opcode 0011011; ins[25:20] for XLEN=64 with opcode 0010011.
- Handshake:
  - ins_ready_output = (occupancy < DEPTH); combinational from state only.
  - Push on ins_valid_input && ins_ready_output.
  - Pop on imm_valid_output && imm_ready_input.
  - imm_valid_output = (occupancy != 0).
- Latency: exactly 1 cycle from push to imm_valid_output; no combinational bypass.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- Full FIFO: a pop in the same cycle does not enable a push; ready is low.
- Pointers wrap modulo DEPTH.
- Head outputs stay stable while valid and not popped.
- Flush: next cycle occupancy is 0 and pointers are 0. Any same-cycle push is discarded. Flush has priority over push and pop.
- Reset mid-operation behaves identically to flush and also restores reset values.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- Defined: opcode 1110011 with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) yields format Z, immediate = ins[19:15] zero-extended.
- Undefined: all 1110011 encodings yield format I, sign-extended from ins[31:20]; code 7 is never produced.

Decomposition:
- Shared package core101_pkg holds:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_IMM32, OP_SYSTEM).
  - the 3-bit IMM_FMT_* codes.
- One combinational sub-module, imm_extract, maps (ins, XLEN) to (fmt, value).
- Top level holds the FIFO storage, pointers and handshake.

Test Plan:
- XLEN=32: push 0xFFF00093 (addi x1,x0,-1) → next cycle valid, value 0xFFFFFFFF, fmt 1, tag echoed.
- Back-to-back 0x00112623, 0xFE000EE3, 0x123452B7 with imm_ready held 1 → values 0x0000000C/S, 0xFFFFFFFC/B, 0x12345000/U, in order, one per cycle.
- imm_ready held 0, push 3 instructions into DEPTH=2 → ins_ready drops after the second push, occupancy 2; release ready → drain in order; the third instruction is accepted only after occupancy < 2.
- XLEN=64: 0x43F0D093 (srai x1,x1,63) → value 0x3F, fmt 6. XLEN=32: 0x01F09093 → value 0x1F, fmt 6.
- Flush while occupancy 2 with a simultaneous valid push → next cycle occupancy 0, valid 0, outputs 0; the pushed instruction never appears.
- With IMM_GEN_ZICSR_EN: 0x3400D073 (csrrwi x0,0x340,1) → value 0x1, fmt 7. Without the macro → value 0x340, fmt 1.
